// File: rtl/axis_result_packetizer.sv
// Result-word packetizer: buffers core results in a small FIFO
// and emits them as one AXI-Stream packet of a programmed length.
module axis_result_packetizer #(
  parameter int DATA_WIDTH = 20,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  in_cnt;
  logic [LEN_WIDTH-1:0]  out_cnt;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic in_last;
  logic out_last;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // in_ready deliberately ignores a same-cycle pop
  assign in_ready      = (state == S_FILL) && !fifo_full;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign m_axis_tlast  = m_axis_tvalid && out_last;
  assign busy          = (state != S_IDLE);

  assign push     = in_valid && in_ready;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign in_last  = (in_cnt + LEN_WIDTH'(1)) == len_q;
  assign out_last = out_cnt == (len_q - LEN_WIDTH'(1));

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      done    <= 1'b0;
      len_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (pkt_len != '0) begin
              len_q   <= pkt_len;
              in_cnt  <= '0;
              out_cnt <= '0;
              state   <= S_FILL;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (push) begin
            in_cnt <= in_cnt + LEN_WIDTH'(1);
            if (in_last) state <= S_DRAIN;
          end
          if (pop) out_cnt <= out_cnt + LEN_WIDTH'(1);
        end
        S_DRAIN: begin
          if (pop) begin
            out_cnt <= out_cnt + LEN_WIDTH'(1);
            if (out_last) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_result_packetizer.sv
// Scoreboard bench for axis_result_packetizer: random traffic,
// queue-based packet model, decoupled output monitor.
module tb_axis_result_packetizer;

  localparam int DW = 20;
  localparam int LW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic          len_err;

  axis_result_packetizer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(16),
    .LEN_WIDTH(LW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .start(start),
    .pkt_len(pkt_len),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy),
    .done(done),
    .len_err(len_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cur_len = 0;
  int   in_idx = 0;
  int   done_cnt = 0;
  bit   exp_done = 0;
  bit   hold_v = 0;
  logic [DW-1:0] hold_d;
  logic          hold_l;

  function automatic void chk(bit ok, string name,
                              longint act, longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Monitor: inputs settle at posedge+1, so negedge sees the
  // handshakes that the next posedge will complete.
  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
      hold_v   = 0;
      exp_done = 0;
    end else begin
      chk(done == exp_done, "done_pulse", done, exp_done);
      if (done) done_cnt++;
      exp_done = 0;
      if (hold_v) begin
        chk(m_axis_tvalid, "tvalid_hold", m_axis_tvalid, 1);
        chk(m_axis_tdata == hold_d, "tdata_hold", m_axis_tdata, hold_d);
        chk(m_axis_tlast == hold_l, "tlast_hold", m_axis_tlast, hold_l);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_word", m_axis_tdata, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(m_axis_tdata == e.d, "tdata", m_axis_tdata, e.d);
          chk(m_axis_tlast == e.l, "tlast", m_axis_tlast, e.l);
          if (e.l) exp_done = 1;
        end
      end
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      hold_l = m_axis_tlast;
      if (in_valid && in_ready) begin
        if (in_idx >= cur_len) begin
          chk(0, "extra_input", in_idx, cur_len);
        end else begin
          exp_q.push_back('{d: in_data, l: (in_idx == cur_len - 1)});
          in_idx++;
        end
      end
    end
  end

  task automatic start_pkt(input int len);
    @(posedge aclk); #1;
    start   = 1'b1;
    pkt_len = LW'(len);
    if (len != 0) begin
      cur_len = len;
      in_idx  = 0;
    end
    @(posedge aclk); #1;
    start = 1'b0;
    if (len != 0) begin
      chk(busy, "busy_after_start", busy, 1);
      chk(in_ready, "in_ready_after_start", in_ready, 1);
    end
  endtask

  task automatic feed(input int pv, input int pr, input int ign_at);
    int cyc = 0;
    int d0  = done_cnt;
    while (done_cnt == d0 && cyc < 3000) begin
      @(posedge aclk); #1;
      in_valid      = ($urandom_range(99) < pv);
      in_data       = DW'($urandom);
      m_axis_tready = ($urandom_range(99) < pr);
      start         = (cyc == ign_at);
      pkt_len       = 7;
      cyc++;
    end
    start = 1'b0;
    chk(done_cnt == d0 + 1, "done_count", done_cnt - d0, 1);
    chk(!busy, "busy_in_done_cycle", busy, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    #12;
    chk(m_axis_tvalid == 0, "rst_tvalid", m_axis_tvalid, 0);
    chk(in_ready == 0, "rst_in_ready", in_ready, 0);
    chk(m_axis_tlast == 0, "rst_tlast", m_axis_tlast, 0);
    chk(m_axis_tdata == 0, "rst_tdata", m_axis_tdata, 0);
    chk(busy == 0, "rst_busy", busy, 0);
    chk(done == 0, "rst_done", done, 0);
    chk(len_err == 0, "rst_len_err", len_err, 0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    // basic packet
    start_pkt(4);
    feed(100, 100, -1);

    // backpressure until the FIFO fills
    start_pkt(20);
    in_valid      = 1'b1;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(posedge aclk); #1;
      in_data = DW'($urandom);
    end
    chk(in_idx == 16, "pushes_when_full", in_idx, 16);
    chk(!in_ready, "in_ready_full", in_ready, 0);
    chk(m_axis_tvalid, "tvalid_full", m_axis_tvalid, 1);
    if (exp_q.size() > 0)
      chk(m_axis_tdata == exp_q[0].d, "head_word", m_axis_tdata, exp_q[0].d);
    feed(100, 100, -1);

    // random stalls
    start_pkt(100);
    feed(60, 50, -1);

    // single-word packet
    start_pkt(1);
    feed(100, 100, -1);

    // zero length
    start_pkt(0);
    chk(len_err, "len_err_pulse", len_err, 1);
    chk(!busy, "len0_busy", busy, 0);
    chk(!in_ready, "len0_in_ready", in_ready, 0);
    @(posedge aclk); #1;
    chk(!len_err, "len_err_single", len_err, 0);

    // start ignored mid-packet
    start_pkt(4);
    feed(100, 100, 2);
    in_valid = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk(!busy, "no_rearm_busy", busy, 0);
    chk(!in_ready, "no_rearm_in_ready", in_ready, 0);
    chk(exp_q.size() == 0, "no_rearm_queue", exp_q.size(), 0);
    in_valid = 1'b0;

    // reset mid-packet
    start_pkt(8);
    in_valid      = 1'b1;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 50 && in_idx < 3; i++) begin
      @(posedge aclk); #1;
      in_data = DW'($urandom);
    end
    chk(in_idx == 3, "pre_reset_pushes", in_idx, 3);
    aresetn = 1'b0;
    #1;
    chk(!m_axis_tvalid, "reset_tvalid", m_axis_tvalid, 0);
    chk(!busy, "reset_busy", busy, 0);
    chk(!in_ready, "reset_in_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn       = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge aclk); #1;
    chk(!m_axis_tvalid, "post_reset_tvalid", m_axis_tvalid, 0);
    start_pkt(2);
    feed(100, 100, -1);

    repeat (3) @(posedge aclk);
    chk(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
